// File: rtl/bcd_display_mux.sv
// Four-digit multiplexed 7-segment driver for BCD values, with frame-coherent
// shadowing, leading-zero blanking and an alert-triggered blink sequence.
module bcd_display_mux #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_DIV    = 125,
    parameter int BLINK_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    input  logic        alert,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic        alert_active
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
    localparam logic [CW-1:0] PAIR_MAX  = CW'(BLINK_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [15:0]   r_sh_digits;
    logic [3:0]    r_sh_dp;
    logic          r_sh_blank;
    logic [3:0]    r_an_sel;
    logic [3:0]    r_an_n;
    logic [6:0]    r_seg_n;
    logic          r_dp_n;
    logic [1:0]    r_state;
    logic [BW-1:0] r_blink_cnt;
    logic [CW-1:0] r_pair_cnt;
    logic          r_alert_active;

    logic          w_tick;
    logic          w_wrap;
    logic [1:0]    w_idx_next;
    logic [15:0]   w_sh_digits;
    logic [3:0]    w_sh_dp;
    logic          w_sh_blank;
    logic [3:0]    w_digit;
    logic [3:0]    w_zero_from;
    logic          w_blank_digit;
    logic [3:0]    w_an_onehot;
    logic [3:0]    w_an_sel_next;
    logic [1:0]    w_state_next;
    logic [BW-1:0] w_blink_next;
    logic [CW-1:0] w_pair_next;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'b1000000;
            4'd1:    f_decode = 7'b1111001;
            4'd2:    f_decode = 7'b0100100;
            4'd3:    f_decode = 7'b0110000;
            4'd4:    f_decode = 7'b0011001;
            4'd5:    f_decode = 7'b0010010;
            4'd6:    f_decode = 7'b0000010;
            4'd7:    f_decode = 7'b1111000;
            4'd8:    f_decode = 7'b0000000;
            4'd9:    f_decode = 7'b0010000;
            default: f_decode = 7'b0111111;
        endcase
    endfunction

    assign w_tick     = (r_presc == PRESC_MAX);
    assign w_wrap     = w_tick && (r_idx == 2'd3);
    assign w_idx_next = r_idx + 2'd1;

    // The first slot of a new frame must already see the freshly captured inputs.
    assign w_sh_digits = w_wrap ? digits_in : r_sh_digits;
    assign w_sh_dp     = w_wrap ? dp_in     : r_sh_dp;
    assign w_sh_blank  = w_wrap ? blank_lz  : r_sh_blank;

    assign w_digit = w_sh_digits[{w_idx_next, 2'b00} +: 4];

    assign w_zero_from[3] = (w_sh_digits[15:12] == 4'd0);
    assign w_zero_from[2] = w_zero_from[3] && (w_sh_digits[11:8] == 4'd0);
    assign w_zero_from[1] = w_zero_from[2] && (w_sh_digits[7:4]  == 4'd0);
    assign w_zero_from[0] = w_zero_from[1] && (w_sh_digits[3:0]  == 4'd0);

    assign w_blank_digit = w_sh_blank && (w_idx_next != 2'd0) && w_zero_from[w_idx_next];

    assign w_an_onehot   = ~(4'b0001 << w_idx_next);
    assign w_an_sel_next = w_tick ? w_an_onehot : r_an_sel;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        w_state_next = r_state;
        w_blink_next = r_blink_cnt;
        w_pair_next  = r_pair_cnt;
        if (alert) begin
            w_state_next = ST_OFF;
            w_blink_next = '0;
            w_pair_next  = '0;
        end else if (r_state != ST_IDLE && w_tick) begin
            if (r_blink_cnt == BLINK_MAX) begin
                w_blink_next = '0;
                if (r_state == ST_OFF) begin
                    w_state_next = ST_ON;
                end else if (r_pair_cnt == PAIR_MAX) begin
                    w_state_next = ST_IDLE;
                    w_pair_next  = '0;
                end else begin
                    w_state_next = ST_OFF;
                    w_pair_next  = r_pair_cnt + CW'(1);
                end
            end else begin
                w_blink_next = r_blink_cnt + BW'(1);
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc     <= '0;
            r_idx       <= 2'd0;
            r_sh_digits <= 16'd0;
            r_sh_dp     <= 4'd0;
            r_sh_blank  <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
                r_idx <= w_idx_next;
            end
            if (w_wrap) begin
                r_sh_digits <= digits_in;
                r_sh_dp     <= dp_in;
                r_sh_blank  <= blank_lz;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an_sel <= 4'hF;
            r_seg_n  <= 7'h7F;
            r_dp_n   <= 1'b1;
        end else if (w_tick) begin
            r_an_sel <= w_an_onehot;
            r_seg_n  <= w_blank_digit ? 7'h7F : f_decode(w_digit);
            r_dp_n   <= ~w_sh_dp[w_idx_next];
        end
    end

    // Anodes follow the blink state every cycle, so OFF takes effect with alert_active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an_n         <= 4'hF;
            r_state        <= ST_IDLE;
            r_blink_cnt    <= '0;
            r_pair_cnt     <= '0;
            r_alert_active <= 1'b0;
        end else begin
            r_an_n         <= (w_state_next == ST_OFF) ? 4'hF : w_an_sel_next;
            r_state        <= w_state_next;
            r_blink_cnt    <= w_blink_next;
            r_pair_cnt     <= w_pair_next;
            r_alert_active <= (w_state_next != ST_IDLE);
        end
    end

    assign seg_n        = r_seg_n;
    assign dp_n         = r_dp_n;
    assign an_n         = r_an_n;
    assign alert_active = r_alert_active;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux with SCAN_DIV=4, BLINK_DIV=2, BLINK_CYCLES=2;
// slot timing is tracked by counting clk edges since reset release.
module tb_bcd_display_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits_in = 16'h1234;
    logic [3:0]  dp_in = 4'b0000;
    logic        blank_lz = 1'b0;
    logic        alert = 1'b0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        alert_active;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bcd_display_mux #(
        .SCAN_DIV    (4),
        .BLINK_DIV   (2),
        .BLINK_CYCLES(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .alert       (alert),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .alert_active(alert_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (cyc != n && guard < 200);
        if (cyc != n) check("wait_cyc_timeout", cyc, n);
    endtask

    task automatic wait_slot(input int idx);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(cyc >= 4 && cyc % 4 == 0 && (cyc / 4) % 4 == idx) && guard < 100);
        if (guard >= 100) check("wait_slot_timeout", 0, 1);
    endtask

    task automatic check_slot(input string tag, input int idx, input logic [6:0] exp_seg,
                              input logic exp_dp);
        wait_slot(idx);
        check({tag, "_an"}, an_n, 4'hF ^ (4'b0001 << idx));
        check({tag, "_seg"}, seg_n, exp_seg);
        check({tag, "_dp"}, dp_n, exp_dp);
    endtask

    // Sends a one-cycle alert landing on a scan-tick edge, optionally re-sent
    // restart_off clocks later, and checks the blanking pattern and length.
    task automatic blink_seq(input int restart_off, input int exp_len, input string tag);
        int  t0, off, rel, len;
        bit  done;
        logic [3:0] exp_an;
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (cyc % 4 != 3 && guard < 10);
        alert = 1'b1;
        @(negedge clk);
        alert = 1'b0;
        t0 = cyc;
        len = 0;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            off = cyc - t0;
            if (alert_active) begin
                len++;
                rel = (restart_off > 0 && off >= restart_off) ? off - restart_off : off;
                exp_an = ((rel % 16) < 8) ? 4'hF : (4'hF ^ (4'b0001 << ((cyc / 4) % 4)));
                check({tag, "_an"}, an_n, exp_an);
            end else begin
                done = 1'b1;
            end
            if (!done) begin
                alert = (restart_off > 0 && off == restart_off - 1);
                @(negedge clk);
            end
        end
        alert = 1'b0;
        check({tag, "_len"}, len, exp_len);
        check({tag, "_an_after"}, an_n, 4'hF ^ (4'b0001 << ((cyc / 4) % 4)));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int highs;

        repeat (3) @(negedge clk);
        check("rst_an", an_n, 4'hF);
        check("rst_seg", seg_n, 7'h7F);
        check("rst_dp", dp_n, 1'b1);
        check("rst_active", alert_active, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        wait_cyc(3);
        check("pre_tick_an", an_n, 4'hF);
        wait_cyc(4);
        check("first_tick_an", an_n, 4'b1101);
        check("first_tick_seg", seg_n, 7'b1000000);

        check_slot("f1234_s0", 0, 7'b0011001, 1'b1);
        check_slot("f1234_s1", 1, 7'b0110000, 1'b1);
        check_slot("f1234_s2", 2, 7'b0100100, 1'b1);
        check_slot("f1234_s3", 3, 7'b1111001, 1'b1);

        digits_in = 16'h0009;
        blank_lz  = 1'b1;
        dp_in     = 4'b0101;
        check_slot("lz_s0", 0, 7'b0010000, 1'b0);
        check_slot("lz_s1", 1, 7'h7F, 1'b1);
        check_slot("lz_s2", 2, 7'h7F, 1'b0);
        check_slot("lz_s3", 3, 7'h7F, 1'b1);

        digits_in = 16'h0005;
        blank_lz  = 1'b0;
        dp_in     = 4'b0000;
        check_slot("tear5_s0", 0, 7'b0010010, 1'b1);
        digits_in = 16'h0004;
        check_slot("tear5_s1", 1, 7'b1000000, 1'b1);
        check_slot("tear4_s0", 0, 7'b0011001, 1'b1);
        digits_in = 16'h00A0;
        check_slot("teara_s1_old", 1, 7'b1000000, 1'b1);
        check_slot("dash_s0", 0, 7'b1000000, 1'b1);
        check_slot("dash_s1", 1, 7'b0111111, 1'b1);

        blink_seq(0, 32, "blink1");
        blink_seq(12, 44, "blink_restart");

        // Abort a running blink from within an ON window.
        do @(negedge clk); while (cyc % 4 != 3);
        alert = 1'b1;
        @(negedge clk);
        alert = 1'b0;
        t0 = cyc;
        wait_cyc(t0 + 10);
        check("on_before_rst_active", alert_active, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_an", an_n, 4'hF);
        check("async_rst_active", alert_active, 1'b0);
        check("async_rst_seg", seg_n, 7'h7F);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(3);
        check("rerst_pre_an", an_n, 4'hF);
        wait_cyc(4);
        check("rerst_s1_an", an_n, 4'b1101);
        check("rerst_s1_seg", seg_n, 7'b1000000);
        highs = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (alert_active) highs++;
        end
        check("rerst_no_residual", highs, 0);
        check_slot("rerst_s0", 0, 7'b1000000, 1'b1);
        check_slot("rerst_s1", 1, 7'b0111111, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
